aes_256: RTL and testbench

- Fully pipelined AES-256 encryption core (FIPS-197, 14 rounds).
- Accepts one 128-bit plaintext block and one 256-bit key every clock cycle.
- Returns the matching ciphertext a fixed 28 cycles later.
- Used as a streaming crypto primitive; it has no handshake, and the caller tracks latency.

---
 rtl/aes_256_if.sv | 36 +++
 rtl/aes_256.sv | 208 ++++++++++++++++++++
 tb/tb_aes_256.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_256_if.sv
// ---------------------------------------------------------------------------
// aes_256_if
//   Streaming bus of the AES-256 pipeline.
//
//   Handshake: there is no flow control. The source presents a new
//   {state, key} pair on every rising edge of clk. The ciphertext of that
//   pair appears on out exactly 28 edges later. When AES_256_VALID_EN is
//   defined, in_valid is a plain sideband tag that travels with each block,
//   and out_valid reports that tag alongside the matching out.
//
//   Signals
//     state     [127:0]  plaintext block, bit 127 = FIPS-197 byte 0
//     key       [255:0]  cipher key, bits 255:248 = key byte 0
//     out       [127:0]  ciphertext, same byte ordering as state
//     in_valid           block tag in      (AES_256_VALID_EN only)
//     out_valid          block tag out     (AES_256_VALID_EN only)
//
//   Modports: master = block source/sink (testbench), slave = the core.
// ---------------------------------------------------------------------------
interface aes_256_if;
  logic [127:0] state;
  logic [255:0] key;
  logic [127:0] out;
`ifdef AES_256_VALID_EN
  logic         in_valid;
  logic         out_valid;

  modport master (output state, output key, output in_valid,
                  input  out,   input  out_valid);
  modport slave  (input  state, input  key,   input  in_valid,
                  output out,   output out_valid);
`else
  modport master (output state, output key, input  out);
  modport slave  (input  state, input  key, output out);
`endif
endinterface

// File: rtl/aes_256.sv
// ---------------------------------------------------------------------------
// aes_256
//   Fully pipelined AES-256 encryption core (FIPS-197, 14 rounds).
//   One {state, key} pair is accepted on every rising edge; its ciphertext
//   is on out right after the 28th following edge and is held for one cycle.
//
//   Ports
//     clk   system clock, all registers update on the rising edge
//     rst   synchronous, active-high; clears every pipeline register and out
//     bus   aes_256_if.slave (state, key in; out back; optional valid tags)
//
//   Optional feature (macro AES_256_VALID_EN): adds bus.in_valid/out_valid
//   and a valid shift register aligned with the data path. The data path
//   itself is identical with or without the macro.
//
//   Pipeline layout (one register per step):
//     in  : state ^ key[255:128] (round-0 AddRoundKey), key window
//     A_r : SubBytes + ShiftRows (+ MixColumns for r < 14) and, in parallel,
//           the next round key of the AES-256 schedule
//     B_r : AddRoundKey with round key r; B_14 is the out register
//   Each block carries its own 256-bit key window {rk[r-1], rk[r]}, so the
//   key may change on every cycle without affecting neighbouring blocks.
// ---------------------------------------------------------------------------
module aes_256 (
  input  logic      clk,
  input  logic      rst,
  aes_256_if.slave  bus
);

  // FIPS-197 forward S-box; entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // -------------------------------------------------------------------------
  // Round helper functions
  // -------------------------------------------------------------------------
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]),
            sub_byte(w[15:8]),  sub_byte(w[7:0])};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows merged: byte (row r, column c) of the result
  // takes the substituted byte from column (c + r) mod 4 of the input.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sub_byte(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Round constant used when producing round key rnd (even rounds only).
  function automatic logic [7:0] rcon(input int rnd);
    logic [7:0] rc;
    case (rnd)
      2:       rc = 8'h01;
      4:       rc = 8'h02;
      6:       rc = 8'h04;
      8:       rc = 8'h08;
      10:      rc = 8'h10;
      12:      rc = 8'h20;
      14:      rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Slide the key window {rk[rnd-2], rk[rnd-1]} to {rk[rnd-1], rk[rnd]}.
  // Even rnd starts a new 8-word group (RotWord + SubWord + Rcon);
  // odd rnd is the mid-group step that applies SubWord only.
  function automatic logic [255:0] expand(input logic [255:0] win,
                                          input int             rnd);
    logic [31:0] t, w0, w1, w2, w3;
    if (rnd % 2 == 0)
      t = sub_word({win[23:0], win[31:24]}) ^ {rcon(rnd), 24'h000000};
    else
      t = sub_word(win[31:0]);
    w0 = win[255:224] ^ t;
    w1 = win[223:192] ^ w0;
    w2 = win[191:160] ^ w1;
    w3 = win[159:128] ^ w2;
    return {win[127:0], w0, w1, w2, w3};
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline registers
  //   b_data[0]/b_win[0] is the input stage; a_*[r] and b_*[r] are the two
  //   halves of round r. Round 14's B stage is out_q.
  // -------------------------------------------------------------------------
  logic [127:0] b_data   [0:13];
  logic [255:0] b_win    [0:13];
  logic [127:0] a_data   [1:14];
  logic [255:0] a_win    [1:14];
  logic [127:0] out_q;

  logic [127:0] b_data_d [0:13];
  logic [255:0] b_win_d  [0:13];
  logic [127:0] a_data_d [1:14];
  logic [255:0] a_win_d  [1:14];
  logic [127:0] out_d;

  always_comb begin
    // Initial AddRoundKey uses the first 128 key bits (round key 0).
    b_data_d[0] = bus.state ^ bus.key[255:128];
    b_win_d[0]  = bus.key;

    for (int r = 1; r <= 14; r++) begin
      a_data_d[r] = (r == 14) ? sub_shift(b_data[r-1])
                              : mix_columns(sub_shift(b_data[r-1]));
      // Round key 1 is the second key half, already in the window.
      a_win_d[r]  = (r == 1) ? b_win[0] : expand(b_win[r-1], r);
    end

    for (int r = 1; r <= 13; r++) begin
      b_data_d[r] = a_data[r] ^ a_win[r][127:0];
      b_win_d[r]  = a_win[r];
    end

    out_d = a_data[14] ^ a_win[14][127:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r <= 13; r++) begin
        b_data[r] <= '0;
        b_win[r]  <= '0;
      end
      for (int r = 1; r <= 14; r++) begin
        a_data[r] <= '0;
        a_win[r]  <= '0;
      end
      out_q <= '0;
    end else begin
      for (int r = 0; r <= 13; r++) begin
        b_data[r] <= b_data_d[r];
        b_win[r]  <= b_win_d[r];
      end
      for (int r = 1; r <= 14; r++) begin
        a_data[r] <= a_data_d[r];
        a_win[r]  <= a_win_d[r];
      end
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

`ifdef AES_256_VALID_EN
  // One tag flop per data register (input stage + 28 round stages), so
  // out_valid lines up with the ciphertext on out.
  logic [28:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst)
      valid_q <= '0;
    else
      valid_q <= {valid_q[27:0], bus.in_valid};
  end

  assign bus.out_valid = valid_q[28];
`endif

endmodule

// File: tb/tb_aes_256.sv
// ---------------------------------------------------------------------------
// tb_aes_256
//   Self-checking bench for aes_256. Known-answer vectors come from a table;
//   random blocks are checked against a byte-array AES-256 model whose
//   S-box is derived from GF(2^8) inversion plus the affine transform.
//   Optional valid tags are exercised when AES_256_VALID_EN is defined.
// ---------------------------------------------------------------------------
module tb_aes_256;

  localparam int LAT = 28;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] A_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] A_KEY   =
    256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] A_CT    = 128'h1a6e6c2c662e7da6501ffb62bc9e93f3;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_256_if bus ();

  aes_256 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [128:0] exp_q[$];   // {valid tag, ciphertext}, one entry per edge
  int           n_checks  = 0;
  int           n_pass    = 0;
  bit           stale_chk = 1'b0;

  typedef struct {
    logic [127:0] pt;
    logic [255:0] key;
    logic [127:0] ct;
    logic         vld;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input bit ok,
                       input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, want);
  endtask

  // -------------------------------------------------------------------------
  // Reference model (FIPS-197 byte-level description)
  // -------------------------------------------------------------------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt,
                                               input logic [255:0] k);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / 8; j++) rc = gmul(rc, 8'h02);
        tmp = ref_sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
      end else if (i % 8 == 4) begin
        tmp = ref_sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int n = 0; n < 16; n++)
      s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = sbox_m[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 14) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int n = 0; n < 16; n++)
        s[n] = s[n] ^ w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Present one block for the next edge, then score the output visible
  // right after that edge against the block sampled LAT edges earlier.
  task automatic drive_block(input logic [127:0] pt, input logic [255:0] k,
                             input logic v, input logic [127:0] ct);
    logic [128:0] e;
    @(negedge clk);
    rst       = 1'b0;
    bus.state = pt;
    bus.key   = k;
`ifdef AES_256_VALID_EN
    bus.in_valid = v;
`endif
    @(posedge clk);
    #1;
    exp_q.push_back({v, ct});
    if (exp_q.size() == LAT + 1) begin
      e = exp_q.pop_front();
      check("ciphertext", bus.out === e[127:0], bus.out, e[127:0]);
`ifdef AES_256_VALID_EN
      check("out_valid", bus.out_valid === e[128],
            {127'd0, bus.out_valid}, {127'd0, e[128]});
`endif
    end else begin
`ifdef AES_256_VALID_EN
      check("out_valid_fill", bus.out_valid === 1'b0,
            {127'd0, bus.out_valid}, 128'd0);
`endif
      if (stale_chk)
        check("discarded_block_absent", bus.out !== FIPS_CT, bus.out, ~FIPS_CT);
    end
  endtask

  task automatic drive_random();
    logic [127:0] pt;
    logic [255:0] k;
    logic         v;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    k  = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    v  = 1'($urandom_range(0, 1));
    drive_block(pt, k, v, ref_encrypt(pt, k));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      bus.state = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.key   = {8{$urandom()}};
`ifdef AES_256_VALID_EN
      bus.in_valid = 1'b1;
`endif
      @(posedge clk);
      #1;
      check("reset_out", bus.out === 128'd0, bus.out, 128'd0);
`ifdef AES_256_VALID_EN
      check("reset_out_valid", bus.out_valid === 1'b0,
            {127'd0, bus.out_valid}, 128'd0);
`endif
    end
    exp_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    bus.state = '0;
    bus.key   = '0;
`ifdef AES_256_VALID_EN
    bus.in_valid = 1'b0;
`endif
    build_sbox();

    // Back-to-back known answers with valid pattern 1,0,1.
    vecs[0] = '{pt: A_PT,    key: A_KEY,    ct: A_CT,    vld: 1'b1};
    vecs[1] = '{pt: FIPS_PT, key: FIPS_KEY, ct: FIPS_CT, vld: 1'b0};
    vecs[2] = '{pt: 128'd0,  key: 256'd0,   ct: ZERO_CT, vld: 1'b1};

    for (int i = 0; i < 3; i++)
      check($sformatf("model_vec%0d", i),
            ref_encrypt(vecs[i].pt, vecs[i].key) === vecs[i].ct,
            ref_encrypt(vecs[i].pt, vecs[i].key), vecs[i].ct);

    do_reset(2);

    for (int i = 0; i < 3; i++)
      drive_block(vecs[i].pt, vecs[i].key, vecs[i].vld, vecs[i].ct);

    repeat (40) drive_random();

    // Reset ten edges after the FIPS block: it must never emerge, and the
    // all-zero block sampled right after reset must emerge on time.
    drive_block(FIPS_PT, FIPS_KEY, 1'b1, FIPS_CT);
    repeat (9) drive_random();
    do_reset(1);
    stale_chk = 1'b1;
    drive_block(128'd0, 256'd0, 1'b1, ZERO_CT);
    repeat (LAT - 1) drive_random();
    stale_chk = 1'b0;
    repeat (30) drive_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
